pwm_cmp_sequencer: RTL and testbench
====================================

// Module: pwm_cmp_sequencer
// PURPOSE
//  Owns the PWM compare value (cmpA) fed to the pwm core. Decodes I2C register writes
//  from i2cregif into a shadow target and commits it to the PWM only at a period boundary.
//  Commits are either immediate or slew-limited (ramped by STEP per PWM period).
//  Sits between i2cregif and pwm in top, all on clk1d. Replaces the inline cmpa always-block.
// PARAMETERS
//  WIDTH      20         compare width; must be >16, because byte 2 covers [WIDTH-1:16]
//  CMP_RST    20'hA0002  cmpA reset value
//  SCR_RST    20'h01342  scratch (shadow) reset value
//  CMP_MAX    20'hFFFFF  upper clamp applied to a committed target
//  STEP_RST   16'h0010   slew step reset value
// PORTS
//  clk           in   1      PWM domain clock (clk1d)
//  rst           in   1      async reset, active-high
//  regAddr       in   3      register address from i2cregif
//  regData       in   8      register write data
//  regDataValid  in   1      1-cycle write strobe
//  period_start  in   1      1-cycle pulse from pwm at counter wrap
//  cmpA          out  WIDTH  compare value to pwm
//  cmp_update    out  1      1-cycle pulse, on the cycle after cmpA changes
//  busy          out  1      high while a commit is pending or a ramp is in progress
// BEHAVIOUR
//  Reset (async, rst=1): cmpA=CMP_RST, scratch=SCR_RST, target=CMP_RST, step=STEP_RST,
//   ramp_en=0, state=IDLE, cmp_update=0, busy=0.
//  Register map (write-only; a write takes effect on the cycle after regDataValid):
//   0: scratch[7:0]
//   1: scratch[15:8]
//   2: scratch[WIDTH-1:16] <= regData[WIDTH-17:0]
//   3: commit. target <= min(scratch, CMP_MAX); then go to PEND if ramp_en=0, else RAMP.
//      regData is ignored.
//   4: step[7:0]
//   5: step[15:8]
//   6: ctrl. ramp_en <= regData[0]
//   7: abort. state -> IDLE; cmpA holds; target <= cmpA.
//  FSM (IDLE, PEND, RAMP):
//   IDLE: cmpA constant.
//   PEND: on period_start, cmpA <= target, then -> IDLE.
//   RAMP: on each period_start,
//    - if |target-cmpA| <= eff_step: cmpA <= target, -> IDLE
//    - else cmpA moves toward target by eff_step (eff_step = step, or 1 when step==0)
//   A commit in PEND or RAMP retargets; the ramp continues from the current cmpA.
//   A commit whose target equals cmpA still passes through PEND/RAMP and completes at
//    the next period_start with no change and no cmp_update.
//  Timing: cmpA changes only on the clk edge where period_start=1 (never mid-period).
//   A commit and period_start on the same cycle: that period_start does NOT apply the
//    commit; it applies at the following period_start.
//   Latency from the commit write to the cmpA change is 1 to 2 PWM periods.
//  Arithmetic: unsigned; step is zero-extended to WIDTH. Up-ramp cannot overflow
//   (clamped at target). Down-ramp cannot underflow (clamped at target).
//  busy = (state != IDLE). Writes to ctrl/step during RAMP take effect at the next step.
//  Reset mid-ramp returns to the reset values immediately (asynchronous).
// STRUCTURE
//  pwm_ctrl_pkg: state enum (IDLE/PEND/RAMP) and register address localparams
//   (REG_B0..REG_ABORT).
//  Sub-module pwm_slew_step: combinational (cur, tgt, step) -> (nxt, done),
//   saturating toward tgt.
//  The sequencer holds the FSM, registers and write decode.
// TESTING
//  Reset: cmpA=20'hA0002, busy=0. Write 0x56/0x34/0x01 to regs 0-2, then commit:
//   cmpA stays 20'hA0002 until period_start; then cmpA=20'h13456, cmp_update pulses once.
//  Commit on the same cycle as period_start: cmpA unchanged at that pulse; updates at
//   the next pulse.
//  ramp_en=1, step=0x1000, cmpA=0x0000, target 0x3800: cmpA=0x1000, 0x2000, 0x3000,
//   then 0x3800 over 4 periods; busy then drops.
//  Down-ramp from 0x3800 to 0x0100 with step=0x2000: 0x1800, then 0x0100 (no underflow).
//  step=0: each period moves by 1.
//  Mid-ramp retarget to a lower value: direction reverses from the current cmpA.
//   Abort (reg 7) freezes cmpA and clears busy.
//  Assert rst mid-ramp: all outputs at reset values asynchronously. After release, a
//   fresh commit works.

Source files
------------

// File: rtl/pwm_cmp_sequencer_pkg.sv
// Shared types and register map for the PWM compare sequencer.
// State encoding, register addresses and the effective-step helper.
package pwm_cmp_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_RAMP = 2'd2
    } seq_state_t;

    localparam logic [2:0] REG_B0      = 3'd0;
    localparam logic [2:0] REG_B1      = 3'd1;
    localparam logic [2:0] REG_B2      = 3'd2;
    localparam logic [2:0] REG_COMMIT  = 3'd3;
    localparam logic [2:0] REG_STEP_LO = 3'd4;
    localparam logic [2:0] REG_STEP_HI = 3'd5;
    localparam logic [2:0] REG_CTRL    = 3'd6;
    localparam logic [2:0] REG_ABORT   = 3'd7;

    // A zero step would stall a ramp forever, so it is treated as a step of one.
    function automatic logic [15:0] eff_step(input logic [15:0] step);
        return (step == 16'd0) ? 16'd1 : step;
    endfunction

endpackage

// File: rtl/pwm_cmp_sequencer_slew_step.sv
// One slew step of the compare value toward its target, saturating at the target.
// Purely combinational; done is set when the target is reached in this step.
module pwm_cmp_sequencer_slew_step
    import pwm_cmp_sequencer_pkg::*;
#(
    parameter int WIDTH = 20
) (
    input  logic [WIDTH-1:0] i_cur,
    input  logic [WIDTH-1:0] i_tgt,
    input  logic [15:0]      i_step,
    output logic [WIDTH-1:0] o_nxt,
    output logic             o_done
);

    logic             w_up;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_step;

    always_comb begin
        w_up   = (i_tgt > i_cur);
        w_diff = w_up ? (i_tgt - i_cur) : (i_cur - i_tgt);
        w_step = {{(WIDTH-16){1'b0}}, eff_step(i_step)};
        o_done = (w_diff <= w_step);
        // Moving by a full step only when the distance exceeds it keeps both directions in range.
        if (o_done) begin
            o_nxt = i_tgt;
        end else if (w_up) begin
            o_nxt = i_cur + w_step;
        end else begin
            o_nxt = i_cur - w_step;
        end
    end

endmodule

// File: rtl/pwm_cmp_sequencer.sv
// Owns the PWM compare value: decodes register writes into a shadow target and
// commits it at PWM period boundaries, either at once or slew-limited.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | compare value constant, nothing pending
// PEND    | commit waiting for the next period start, applied in one jump
// RAMP    | compare moves toward target by one step per period start
module pwm_cmp_sequencer
    import pwm_cmp_sequencer_pkg::*;
#(
    parameter int               WIDTH    = 20,
    parameter logic [WIDTH-1:0] CMP_RST  = 20'hA0002,
    parameter logic [WIDTH-1:0] SCR_RST  = 20'h01342,
    parameter logic [WIDTH-1:0] CMP_MAX  = 20'hFFFFF,
    parameter logic [15:0]      STEP_RST = 16'h0010
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [2:0]       i_reg_addr,
    input  logic [7:0]       i_reg_data,
    input  logic             i_reg_data_valid,
    input  logic             i_period_start,
    output logic [WIDTH-1:0] o_cmp_a,
    output logic             o_cmp_update,
    output logic             o_busy
);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_cmp;
    logic [WIDTH-1:0] w_cmp_nxt;
    logic             r_cmp_update;
    logic [WIDTH-1:0] r_scratch;
    logic [WIDTH-1:0] r_target;
    logic [15:0]      r_step;
    logic             r_ramp_en;

    logic             w_wr_commit;
    logic             w_wr_abort;
    logic [WIDTH-1:0] w_commit_tgt;
    logic [WIDTH-1:0] w_slew_nxt;
    logic             w_slew_done;

    assign w_wr_commit  = i_reg_data_valid && (i_reg_addr == REG_COMMIT);
    assign w_wr_abort   = i_reg_data_valid && (i_reg_addr == REG_ABORT);
    assign w_commit_tgt = (r_scratch > CMP_MAX) ? CMP_MAX : r_scratch;

    pwm_cmp_sequencer_slew_step #(
        .WIDTH (WIDTH)
    ) u_slew (
        .i_cur  (r_cmp),
        .i_tgt  (r_target),
        .i_step (r_step),
        .o_nxt  (w_slew_nxt),
        .o_done (w_slew_done)
    );

    // A commit or abort in the same cycle as a period start wins; the compare value
    // is left alone on that edge and the new request is served from the next period.
    always_comb begin
        w_state_nxt = r_state;
        w_cmp_nxt   = r_cmp;
        if (w_wr_commit) begin
            w_state_nxt = r_ramp_en ? ST_RAMP : ST_PEND;
        end else if (w_wr_abort) begin
            w_state_nxt = ST_IDLE;
        end else if (i_period_start) begin
            case (r_state)
                ST_PEND: begin
                    w_cmp_nxt   = r_target;
                    w_state_nxt = ST_IDLE;
                end
                ST_RAMP: begin
                    w_cmp_nxt = w_slew_nxt;
                    if (w_slew_done) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_cmp        <= CMP_RST;
            r_cmp_update <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cmp        <= w_cmp_nxt;
            r_cmp_update <= (w_cmp_nxt != r_cmp);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_scratch <= SCR_RST;
            r_target  <= CMP_RST;
            r_step    <= STEP_RST;
            r_ramp_en <= 1'b0;
        end else if (i_reg_data_valid) begin
            case (i_reg_addr)
                REG_B0:      r_scratch[7:0]        <= i_reg_data;
                REG_B1:      r_scratch[15:8]       <= i_reg_data;
                REG_B2:      r_scratch[WIDTH-1:16] <= i_reg_data[WIDTH-17:0];
                REG_COMMIT:  r_target              <= w_commit_tgt;
                REG_STEP_LO: r_step[7:0]           <= i_reg_data;
                REG_STEP_HI: r_step[15:8]          <= i_reg_data;
                REG_CTRL:    r_ramp_en             <= i_reg_data[0];
                REG_ABORT:   r_target              <= r_cmp;
                default:     r_target              <= r_target;
            endcase
        end
    end

    assign o_cmp_a      = r_cmp;
    assign o_cmp_update = r_cmp_update;
    assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pwm_cmp_sequencer.sv
// Bench for pwm_cmp_sequencer: directed scenarios with literal expectations, then
// randomized register traffic, all checked each cycle against a behavioural model.
module tb_pwm_cmp_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  addr;
    logic [7:0]  data;
    logic        valid;
    logic        ps;
    logic [19:0] cmp;
    logic        upd;
    logic        busy;

    int total = 0;
    int bad   = 0;

    pwm_cmp_sequencer dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_reg_addr       (addr),
        .i_reg_data       (data),
        .i_reg_data_valid (valid),
        .i_period_start   (ps),
        .o_cmp_a          (cmp),
        .o_cmp_update     (upd),
        .o_busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 = nothing pending, 1 = jump at next period, 2 = ramping.
    int m_cmp, m_tgt, m_scr, m_step, m_ramp, m_mode, m_upd;
    int m_old, m_dist, m_es;
    bit m_blocked;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cmp = 'hA0002; m_tgt = 'hA0002; m_scr = 'h01342;
            m_step = 'h0010; m_ramp = 0; m_mode = 0; m_upd = 0;
        end else begin
            m_old     = m_cmp;
            m_blocked = valid && (addr == 3'd3 || addr == 3'd7);
            if (ps && !m_blocked && m_mode == 1) begin
                m_cmp  = m_tgt;
                m_mode = 0;
            end else if (ps && !m_blocked && m_mode == 2) begin
                m_es   = (m_step == 0) ? 1 : m_step;
                m_dist = m_tgt - m_cmp;
                if (m_dist <= m_es && m_dist >= -m_es) begin
                    m_cmp  = m_tgt;
                    m_mode = 0;
                end else begin
                    m_cmp = m_cmp + ((m_dist > 0) ? m_es : -m_es);
                end
            end
            m_upd = (m_cmp != m_old);
            if (valid) begin
                case (addr)
                    3'd0: m_scr  = (m_scr & 'hFFF00) | int'(data);
                    3'd1: m_scr  = (m_scr & 'hF00FF) | (int'(data) << 8);
                    3'd2: m_scr  = (m_scr & 'h0FFFF) | ((int'(data) & 'hF) << 16);
                    3'd3: begin
                        m_tgt  = (m_scr > 'hFFFFF) ? 'hFFFFF : m_scr;
                        m_mode = m_ramp ? 2 : 1;
                    end
                    3'd4: m_step = (m_step & 'hFF00) | int'(data);
                    3'd5: m_step = (m_step & 'h00FF) | (int'(data) << 8);
                    3'd6: m_ramp = int'(data) & 1;
                    default: begin
                        m_mode = 0;
                        m_tgt  = m_cmp;
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_model", int'(cmp), m_cmp);
        chk("upd_model", int'(upd), m_upd);
        chk("busy_model", int'(busy), int'(m_mode != 0));
    end

    // Stimulus tasks start and end right after a falling edge.
    task automatic wr(input int a, input int d);
        addr = 3'(a); data = 8'(d); valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic per();
        ps = 1'b1;
        @(negedge clk);
        ps = 1'b0;
    endtask

    task automatic expect_cmp(input string name, input int c, input int b);
        chk({name, "_cmp"}, int'(cmp), c);
        chk({name, "_busy"}, int'(busy), b);
    endtask

    int cnt;

    initial begin
        rst = 1'b1; addr = 3'd0; data = 8'd0; valid = 1'b0; ps = 1'b0;
        repeat (2) @(negedge clk);
        expect_cmp("reset", 'hA0002, 0);
        chk("reset_upd", int'(upd), 0);
        rst = 1'b0;
        @(negedge clk);

        // Immediate commit.
        wr(0, 'h56); wr(1, 'h34); wr(2, 'h01); wr(3, 0);
        expect_cmp("commit_wait", 'hA0002, 1);
        repeat (3) @(negedge clk);
        expect_cmp("commit_hold", 'hA0002, 1);
        per();
        expect_cmp("commit_apply", 'h13456, 0);
        chk("commit_upd", int'(upd), 1);
        @(negedge clk);
        chk("commit_upd_once", int'(upd), 0);

        // Commit coinciding with a period start.
        wr(0, 'h22); wr(1, 'h02); wr(2, 'h00);
        addr = 3'd3; valid = 1'b1; ps = 1'b1;
        @(negedge clk);
        valid = 1'b0; ps = 1'b0;
        expect_cmp("same_cycle", 'h13456, 1);
        @(negedge clk);
        per();
        expect_cmp("same_cycle_next", 'h00222, 0);

        // Up-ramp from zero.
        wr(0, 0); wr(1, 0); wr(3, 0); per();
        expect_cmp("zero", 0, 0);
        wr(4, 'h00); wr(5, 'h10); wr(6, 1); wr(1, 'h38); wr(3, 0);
        per(); expect_cmp("up1", 'h1000, 1);
        per(); expect_cmp("up2", 'h2000, 1);
        per(); expect_cmp("up3", 'h3000, 1);
        per(); expect_cmp("up4", 'h3800, 0);

        // Down-ramp with a step larger than the remaining distance.
        wr(5, 'h20); wr(1, 'h01); wr(3, 0);
        per(); expect_cmp("down1", 'h1800, 1);
        per(); expect_cmp("down2", 'h0100, 0);

        // Zero step moves by one.
        wr(5, 0); wr(0, 'h03); wr(3, 0);
        per(); expect_cmp("s0_1", 'h0101, 1);
        per(); expect_cmp("s0_2", 'h0102, 1);
        per(); expect_cmp("s0_3", 'h0103, 0);

        // Retarget mid-ramp, then abort.
        wr(5, 'h01); wr(0, 0); wr(1, 'h08); wr(3, 0);
        per(); expect_cmp("rt1", 'h0203, 1);
        per(); expect_cmp("rt2", 'h0303, 1);
        wr(1, 0); wr(3, 0);
        per(); expect_cmp("rt_rev", 'h0203, 1);
        wr(7, 0);
        expect_cmp("abort", 'h0203, 0);
        per(); expect_cmp("abort_hold", 'h0203, 0);
        chk("abort_upd", int'(upd), 0);

        // Asynchronous reset mid-ramp.
        wr(1, 'h50); wr(3, 0);
        per(); expect_cmp("pre_rst", 'h0303, 1);
        #2 rst = 1'b1;
        #1;
        expect_cmp("async_rst", 'hA0002, 0);
        chk("async_rst_upd", int'(upd), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wr(3, 0); per();
        expect_cmp("post_rst", 'h01342, 0);
        chk("post_rst_upd", int'(upd), 1);

        // Commit equal to current value: passes through, no update pulse.
        wr(3, 0);
        expect_cmp("same_val_wait", 'h01342, 1);
        per();
        expect_cmp("same_val_done", 'h01342, 0);
        chk("same_val_upd", int'(upd), 0);

        // Randomized traffic.
        cnt = 3;
        for (int i = 0; i < 4000; i++) begin
            valid = ($urandom_range(0, 3) == 0);
            addr  = 3'($urandom_range(0, 7));
            if (addr == 3'd7 && $urandom_range(0, 3) != 0) addr = 3'd3;
            data  = 8'($urandom);
            if (addr == 3'd5) data = 8'($urandom_range(0, 3));
            ps    = (cnt == 0);
            cnt   = (cnt == 0) ? $urandom_range(2, 8) : cnt - 1;
            @(negedge clk);
        end
        valid = 1'b0; ps = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
